shift_pipe: RTL and testbench
=============================

# shift_pipe

Parametrised, pipelined barrel shifter that succeeds the combinational 32-bit SHIFT32 in the CPU datapath. Adds logical, arithmetic and rotate modes, configurable data width, and an out-of-range shift policy. One registered stage per shift-amount bit, with a valid/ready handshake and full-pipeline stall on backpressure. Sits between the register-read stage and the writeback mux, alongside the ALU.

## Interface
- WIDTH, 32: data width; power of two, ≥ 4.
- STAGES, $clog2(WIDTH): number of shift stages (derived; do not override).
- SW, $clog2(WIDTH)+1: shift-amount width; the extra bit allows amounts up to 2·WIDTH−1.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-high.
- VALID_IN  input  1  operand valid.
- READY_IN  output  1  block can accept an operand this cycle.
- D  input  WIDTH  data to shift.
- S  input  SW  shift amount, unsigned.
- LnR  input  1  direction: 1 = left, 0 = right.
- MODE  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- VALID_OUT  output  1  Y/Z hold a result.
- READY_OUT  input  1  consumer accepts the result.
- Y  output  WIDTH  shifted result.
- Z  output  1  high when Y == 0.

## Operation
- Accept when VALID_IN && READY_IN. Latch D, S[STAGES−1:0], LnR, MODE, and the range flag OOR = (S ≥ WIDTH) into stage 0.
- Stage k (0..STAGES−1) shifts by 2^k when S bit k is set; otherwise it passes data through. Control fields travel with the data.
- Fill rules:
  - Logical: zeros enter.
  - Arithmetic right: copies of the original D[WIDTH−1] enter. The sign bit is latched at stage 0 and carried with the data.
  - Arithmetic left: identical to logical left.
  - Rotate: bits shifted out re-enter from the other end.
- Out-of-range amounts (OOR = 1), overriding the last-stage result:
  - Logical: Y = 0.
  - Arithmetic right: Y = all sign bits.
  - Arithmetic left: Y = 0.
  - Rotate: no override; the amount is taken modulo WIDTH by using only the low STAGES bits.
- S = 0: Y = D in every mode.
- Z is computed combinationally from the final-stage Y and registered with it in the last stage.
- Reserved MODE 11 behaves exactly as 00.

## Timing
- Latency is STAGES cycles without stall: an operand accepted at edge n gives VALID_OUT = 1 with its result after edge n+STAGES−1. WIDTH=32 gives 5 cycles.
- Throughput is one operation per cycle when READY_OUT is held high.
- Advance signal: adv = !VALID_OUT || READY_OUT. READY_IN = adv, combinational.
- When adv = 0, every stage holds, including bubbles; the pipeline does not compact.
- When adv = 1, every stage loads from its predecessor. Stage 0 loads the new operand, or a bubble if VALID_IN = 0.
- Each stage has a valid bit; a result leaves on the edge where VALID_OUT && READY_OUT.
- Y and Z are stable while VALID_OUT && !READY_OUT.
- Reset values (immediate on RST rise):
  - All stage valid bits, VALID_OUT and Z = 0.
  - Y and all stage data and control registers = 0.
  - READY_IN = 1 once RST is low.
- Reset mid-operation: in-flight operands are discarded, not completed. The first post-reset acceptance behaves as if from idle.
- VALID_IN ignored while RST = 1.
- Inputs are sampled only on accepting edges; they may change freely otherwise.

## Test plan
- WIDTH=32, logical:
  - D=0x8, S=2, LnR=1 → Y=0x20.
  - LnR=0 → Y=0x2.
  - S=4 left → 0x80; right → 0x0, Z=1.
  - Each result appears exactly 5 cycles after acceptance.
- Out-of-range:
  - D=0x8, S=32, logical left/right → Y=0, Z=1.
  - D=0x80000000, S=33, arithmetic right → Y=0xFFFFFFFF.
  - D=0x8, S=33, rotate left → Y=0x10.
- Arithmetic and rotate:
  - D=0x80000000, S=4, arithmetic right → 0xF8000000.
  - D=0x8, S=4, rotate right → 0x80000000.
  - D=0x8, S=0, any mode → 0x8.
- Streaming plus backpressure:
  - Issue 8 back-to-back operands. Drop READY_OUT for 3 cycles mid-stream.
  - READY_IN mirrors the stall; Y stays stable throughout; all 8 results emerge in order with no loss or duplication.
- Reset mid-operation:
  - Assert RST asynchronously (between edges) with 3 operands in flight.
  - VALID_OUT and Y go to 0 immediately, and no stale result appears afterward.
  - The next operand has normal 5-cycle latency.
- WIDTH=8 instance:
  - D=0x81, S=1, rotate left → 0x03.
  - S=8, logical right → 0x00.
  - Latency 3 cycles.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (logical / arithmetic / rotate).
// Stage k applies the 2^k shift step. The last stage also applies the
// out-of-range override and produces the registered Y/Z/VALID_OUT.
// The whole pipeline advances together or holds together.
module shift_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = $clog2(WIDTH),
  parameter int unsigned SW     = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VALID_IN,
  output logic             READY_IN,
  input  logic [WIDTH-1:0] D,
  input  logic [SW-1:0]    S,
  input  logic             LnR,
  input  logic [1:0]       MODE,
  output logic             VALID_OUT,
  input  logic             READY_OUT,
  output logic [WIDTH-1:0] Y,
  output logic             Z
);

  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;
  localparam int unsigned NPASS   = STAGES - 1;

  // Payload carried between stages; sgn is the operand's original MSB.
  typedef struct packed {
    logic              vld;
    logic [WIDTH-1:0]  dat;
    logic [STAGES-1:0] amt;
    logic              lnr;
    logic [1:0]        mode;
    logic              oor;
    logic              sgn;
  } stage_t;

  stage_t           op;
  stage_t           stg_q [NPASS];
  stage_t           stg_d [NPASS];
  logic             last_vld;
  logic [WIDTH-1:0] last_dat;
  logic             adv;

  // Global advance: everything moves unless a finished result is blocked.
  assign adv      = !VALID_OUT || READY_OUT;
  assign READY_IN = adv;

  // Incoming operand; S >= WIDTH is exactly the top bit of S.
  always_comb begin
    op      = '0;
    op.vld  = VALID_IN;
    op.dat  = D;
    op.amt  = S[STAGES-1:0];
    op.lnr  = LnR;
    op.mode = MODE;
    op.oor  = S[SW-1];
    op.sgn  = D[WIDTH-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;

    stage_t           src;
    logic [SH-1:0]    lfill;
    logic [SH-1:0]    rfill;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sft;
    logic             rot;
    logic             ari;

    if (k == 0) begin : g_first
      assign src = op;
    end else begin : g_mid
      assign src = stg_q[k-1];
    end

    // Conditional 2^k shift step with mode-dependent fill bits.
    always_comb begin
      rot   = (src.mode == MODE_ROT);
      ari   = (src.mode == MODE_ARI);
      lfill = rot ? src.dat[WIDTH-1 -: SH] : '0;
      rfill = rot ? src.dat[SH-1:0] : (ari ? {SH{src.sgn}} : '0);
      shl   = {src.dat[WIDTH-1-SH:0], lfill};
      shr   = {rfill, src.dat[WIDTH-1:SH]};
      sft   = src.amt[k] ? (src.lnr ? shl : shr) : src.dat;
    end

    if (k < STAGES - 1) begin : g_pass
      stage_t nxt;

      // Forward control fields unchanged alongside the partial result.
      always_comb begin
        nxt     = src;
        nxt.dat = sft;
      end

      assign stg_d[k] = nxt;
    end else begin : g_last
      // Out-of-range override; rotate keeps the modulo-WIDTH result.
      always_comb begin
        last_vld = src.vld;
        last_dat = sft;
        if (src.oor && !rot) begin
          last_dat = (ari && !src.lnr) ? {WIDTH{src.sgn}} : '0;
        end
      end
    end
  end

  // Pipeline registers; reset flushes all in-flight operands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(NPASS); i++) begin
        stg_q[i] <= '0;
      end
      VALID_OUT <= 1'b0;
      Y         <= '0;
      Z         <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < int'(NPASS); i++) begin
        stg_q[i] <= stg_d[i];
      end
      VALID_OUT <= last_vld;
      Y         <= last_dat;
      Z         <= (last_dat == '0);
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: 32-bit and 8-bit instances.
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst;

  // 32-bit instance signals
  logic        v32, rdy32, lnr32, vo32, ro32, z32;
  logic [31:0] d32, y32;
  logic [5:0]  s32;
  logic [1:0]  m32;

  // 8-bit instance signals
  logic        v8, rdy8, lnr8, vo8, ro8, z8;
  logic [7:0]  d8, y8;
  logic [3:0]  s8;
  logic [1:0]  m8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32)) u_dut32 (
    .CLK(clk), .RST(rst), .VALID_IN(v32), .READY_IN(rdy32), .D(d32), .S(s32),
    .LnR(lnr32), .MODE(m32), .VALID_OUT(vo32), .READY_OUT(ro32), .Y(y32), .Z(z32)
  );

  shift_pipe #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .VALID_IN(v8), .READY_IN(rdy8), .D(d8), .S(s8),
    .LnR(lnr8), .MODE(m8), .VALID_OUT(vo8), .READY_OUT(ro8), .Y(y8), .Z(z8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation; called at posedge+1, returns at posedge+1.
  task automatic run_op(input bit w8, input logic [31:0] d, input logic [5:0] s,
                        input logic lnr, input logic [1:0] mode,
                        input logic [31:0] exp, input string tag);
    int lat;
    if (w8) begin
      v8 = 1'b1; d8 = d[7:0]; s8 = s[3:0]; lnr8 = lnr; m8 = mode;
    end else begin
      v32 = 1'b1; d32 = d; s32 = s; lnr32 = lnr; m32 = mode;
    end
    #1;
    check({tag, "/rdy"}, 32'(w8 ? rdy8 : rdy32), 32'd1);
    @(posedge clk); #1;
    v8  = 1'b0;
    v32 = 1'b0;
    lat = 0;
    while (!(w8 ? vo8 : vo32) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), w8 ? 32'd2 : 32'd4);
    check({tag, "/y"}, w8 ? {24'b0, y8} : y32, exp);
    check({tag, "/z"}, 32'(w8 ? z8 : z32), 32'(exp == 32'd0));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sb [$];
    logic [31:0] head;
    int issued, got, t, stale;

    rst = 1'b1;
    v32 = 1'b0; d32 = '0; s32 = '0; lnr32 = 1'b0; m32 = '0; ro32 = 1'b1;
    v8  = 1'b0; d8  = '0; s8  = '0; lnr8  = 1'b0; m8  = '0; ro8  = 1'b1;

    #12;
    check("rst/vout", 32'(vo32), 32'd0);
    check("rst/y", y32, 32'd0);
    check("rst/z", 32'(z32), 32'd0);
    rst = 1'b0;
    #1;
    check("rst/rdy", 32'(rdy32), 32'd1);
    @(posedge clk); #1;

    // Logical
    run_op(0, 32'h8, 6'd2, 1'b1, 2'b00, 32'h20, "log_l2");
    run_op(0, 32'h8, 6'd2, 1'b0, 2'b00, 32'h2,  "log_r2");
    run_op(0, 32'h8, 6'd4, 1'b1, 2'b00, 32'h80, "log_l4");
    run_op(0, 32'h8, 6'd4, 1'b0, 2'b00, 32'h0,  "log_r4");
    run_op(0, 32'h8, 6'd2, 1'b0, 2'b11, 32'h2,  "rsv_r2");

    // Out-of-range
    run_op(0, 32'h8, 6'd32, 1'b1, 2'b00, 32'h0, "oor_log_l");
    run_op(0, 32'h8, 6'd32, 1'b0, 2'b00, 32'h0, "oor_log_r");
    run_op(0, 32'h80000000, 6'd33, 1'b0, 2'b01, 32'hFFFFFFFF, "oor_ari_r");
    run_op(0, 32'h8, 6'd33, 1'b1, 2'b01, 32'h0,  "oor_ari_l");
    run_op(0, 32'h8, 6'd33, 1'b1, 2'b10, 32'h10, "oor_rot_l");

    // Arithmetic and rotate
    run_op(0, 32'h80000000, 6'd4, 1'b0, 2'b01, 32'hF8000000, "ari_r4");
    run_op(0, 32'h80000001, 6'd1, 1'b1, 2'b01, 32'h2,        "ari_l1");
    run_op(0, 32'h40000000, 6'd31, 1'b0, 2'b01, 32'h0,       "ari_r31");
    run_op(0, 32'h8, 6'd4, 1'b0, 2'b10, 32'h80000000,        "rot_r4");
    for (int m = 0; m < 4; m++) begin
      run_op(0, 32'h8, 6'd0, 1'b0, 2'(m), 32'h8, $sformatf("s0_m%0d", m));
    end

    // Streaming with a 3-cycle backpressure window
    issued = 0; got = 0; t = 0;
    while (got < 8 && t < 60) begin
      ro32  = !(t >= 6 && t < 9);
      v32   = (issued < 8);
      d32   = 32'(issued + 1);
      s32   = 6'(issued % 4);
      lnr32 = 1'b1;
      m32   = 2'b00;
      #1;
      head = (sb.size() > 0) ? sb[0] : 32'hDEADBEEF;
      if (t >= 6 && t < 9) begin
        check("strm/rdy_stall", 32'(rdy32), 32'd0);
        check("strm/vout_stall", 32'(vo32), 32'd1);
        check("strm/y_hold", y32, head);
      end else begin
        check("strm/rdy", 32'(rdy32), 32'd1);
      end
      if (vo32 && ro32) begin
        if (sb.size() == 0) begin
          check("strm/extra", 32'd1, 32'd0);
        end else begin
          check($sformatf("strm/y%0d", got), y32, sb.pop_front());
        end
        got++;
      end
      if (v32 && rdy32) begin
        sb.push_back(32'((issued + 1) << (issued % 4)));
        issued++;
      end
      @(posedge clk); #1;
      t++;
    end
    v32  = 1'b0;
    ro32 = 1'b1;
    check("strm/count", 32'(got), 32'd8);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (vo32) stale++;
      @(posedge clk); #1;
    end
    check("strm/dup", 32'(stale), 32'd0);

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++) begin
      v32 = 1'b1; d32 = 32'h1 << i; s32 = 6'd1; lnr32 = 1'b1; m32 = 2'b00;
      @(posedge clk); #1;
    end
    v32 = 1'b0;
    #3;
    rst = 1'b1;
    v32 = 1'b1;
    #1;
    check("mrst/vout", 32'(vo32), 32'd0);
    check("mrst/y", y32, 32'd0);
    check("mrst/z", 32'(z32), 32'd0);
    @(posedge clk);
    @(posedge clk); #3;
    v32 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (vo32) stale++;
      @(posedge clk); #1;
    end
    check("mrst/stale", 32'(stale), 32'd0);
    run_op(0, 32'h8, 6'd2, 1'b1, 2'b00, 32'h20, "mrst_next");

    // 8-bit instance
    run_op(1, 32'h81, 6'd1, 1'b1, 2'b10, 32'h03, "w8_rot_l1");
    run_op(1, 32'h81, 6'd8, 1'b0, 2'b00, 32'h00, "w8_oor_r");
    run_op(1, 32'h81, 6'd3, 1'b0, 2'b01, 32'hF0, "w8_ari_r3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
